// File: rtl/muldiv_sequencer.sv
// HI/LO owner for the MIPS mult/multu/div/divu group: a 32-step shift-add /
// restoring-divide sequencer with a sign-fixup cycle, plus mthi/mtlo/mfhi/mflo.
//
// Handshake: a request is Md_valid with a recognised funct. In IDLE it is
// consumed at the rising edge. While Busy it is refused by Stall and must be
// held by the pipeline until it is consumed. Unrecognised functs are ignored.
module muldiv_sequencer #(
  parameter int ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Md_valid,
  input  logic [5:0]  Function_opcode,
  input  logic [31:0] Read_data_1,
  input  logic [31:0] Read_data_2,
  output logic        Busy,
  output logic        Done,
  output logic        Stall,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic [31:0] Mf_Result
);

  localparam int CW = $clog2(ITER);
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  localparam logic [5:0] F_MFHI = 6'b010000;
  localparam logic [5:0] F_MTHI = 6'b010001;
  localparam logic [5:0] F_MFLO = 6'b010010;
  localparam logic [5:0] F_MTLO = 6'b010011;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   acc_q, acc_d;
  logic [31:0]   opnd_q, opnd_d;
  logic [31:0]   rs_q, rs_d;
  logic          sgn_q, sgn_d;
  logic          sa_q, sa_d;
  logic          sb_q, sb_d;
  logic          div_q, div_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic          done_q, done_d;

  // Decode: arithmetic ops are 0110xx, HI/LO moves are 0100xx.
  logic arith_f, hilo_f, recog_f;
  assign arith_f = (Function_opcode[5:2] == 4'b0110);
  assign hilo_f  = (Function_opcode[5:2] == 4'b0100);
  assign recog_f = arith_f | hilo_f;

  assign Busy  = (state_q != S_IDLE);
  assign Done  = done_q;
  assign Stall = Md_valid & recog_f & Busy;
  assign Hi    = hi_q;
  assign Lo    = lo_q;

  always_comb begin
    Mf_Result = 32'd0;
    if (Function_opcode == F_MFHI) Mf_Result = hi_q;
    else if (Function_opcode == F_MFLO) Mf_Result = lo_q;
  end

  // Operand magnitudes: funct[0]=0 means signed, funct[1]=1 means divide.
  logic        op_signed, in_sa, in_sb;
  logic [31:0] mag_a, mag_b;
  assign op_signed = ~Function_opcode[0];
  assign in_sa     = op_signed & Read_data_1[31];
  assign in_sb     = op_signed & Read_data_2[31];
  assign mag_a     = in_sa ? (32'd0 - Read_data_1) : Read_data_1;
  assign mag_b     = in_sb ? (32'd0 - Read_data_2) : Read_data_2;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
  // The shifted remainder is below 2*divisor, so bit 32 of the 33-bit
  // difference is a reliable sign.
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [63:0] div_next;
  assign div_shift = acc_q[63:31];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = ~div_diff[32];
  assign div_next  = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};

  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  assign prod_fix = (sgn_q & (sa_q ^ sb_q)) ? (64'd0 - acc_q) : acc_q;
  assign quo_fix  = (sgn_q & (sa_q ^ sb_q)) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
  assign rem_fix  = (sgn_q & sa_q) ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    rs_d    = rs_q;
    sgn_d   = sgn_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    div_d   = div_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Md_valid && arith_f) begin
          state_d = S_CALC;
          cnt_d   = '0;
          acc_d   = Function_opcode[1] ? {32'd0, mag_a} : {32'd0, mag_b};
          opnd_d  = Function_opcode[1] ? mag_b : mag_a;
          rs_d    = Read_data_1;
          sgn_d   = op_signed;
          sa_d    = in_sa;
          sb_d    = in_sb;
          div_d   = Function_opcode[1];
          dz_d    = (Read_data_2 == 32'd0);
          ovf_d   = op_signed & (Read_data_1 == 32'h8000_0000) &
                    (Read_data_2 == 32'hFFFF_FFFF);
        end else if (Md_valid && Function_opcode == F_MTHI) begin
          hi_d = Read_data_1;
        end else if (Md_valid && Function_opcode == F_MTLO) begin
          lo_d = Read_data_1;
        end
      end
      S_CALC: begin
        acc_d = div_q ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (div_q) begin
          if (dz_q) begin
            hi_d = rs_q;
            lo_d = 32'hFFFF_FFFF;
          end else if (ovf_q) begin
            hi_d = 32'd0;
            lo_d = 32'h8000_0000;
          end else begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      rs_q    <= '0;
      sgn_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      rs_q    <= rs_d;
      sgn_q   <= sgn_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus random
// arithmetic ops checked against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_ADD   = 6'b100000;

  logic        clock = 1'b0;
  logic        reset;
  logic        Md_valid;
  logic [5:0]  Function_opcode;
  logic [31:0] Read_data_1, Read_data_2;
  logic        Busy, Done, Stall;
  logic [31:0] Hi, Lo, Mf_Result;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  muldiv_sequencer dut (
    .clock          (clock),
    .reset          (reset),
    .Md_valid       (Md_valid),
    .Function_opcode(Function_opcode),
    .Read_data_1    (Read_data_1),
    .Read_data_2    (Read_data_2),
    .Busy           (Busy),
    .Done           (Done),
    .Stall          (Stall),
    .Hi             (Hi),
    .Lo             (Lo),
    .Mf_Result      (Mf_Result)
  );

  // Clock block.
  always #5 clock = ~clock;

  // Reference model: {HI, LO} from ordinary integer arithmetic.
  function automatic logic [63:0] ref_md(input logic [5:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint sp;
    int     sa, sb, q, r;
    case (f)
      F_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return sp;
      end
      F_MULTU: return {32'd0, a} * {32'd0, b};
      F_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: present an arithmetic op in IDLE; returns one cycle after accept.
  task automatic start_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    Md_valid = 1'b1;
    Function_opcode = f;
    Read_data_1 = a;
    Read_data_2 = b;
    @(negedge clock);
    check("start.stall", 32'(Stall), 32'd0);
    @(posedge clock);
    #1;
    Md_valid = 1'b0;
    exp_q.push_back(ref_md(f, a, b));
  endtask

  // Runs until Busy drops (bounded); returns at the negedge of the Done cycle.
  task automatic wait_done(output int busy_n, output int stall_n, output int hold_bad);
    busy_n = 0;
    stall_n = 0;
    hold_bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (!Busy) return;
      busy_n++;
      if (Stall) stall_n++;
      if (Hi !== m_hi || Lo !== m_lo || Done !== 1'b0) hold_bad++;
      @(posedge clock);
      #1;
    end
  endtask

  // Scoreboard: compare the Done-cycle HI/LO with the oldest expected result.
  task automatic expect_result(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    m_hi = e[63:32];
    m_lo = e[31:0];
    check({tag, ".done"}, 32'(Done), 32'd1);
    check({tag, ".hi"}, Hi, m_hi);
    check({tag, ".lo"}, Lo, m_lo);
  endtask

  task automatic run_arith(input string tag, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] b);
    int bn, sn, hb;
    start_op(f, a, b);
    wait_done(bn, sn, hb);
    check({tag, ".busy_cycles"}, 32'(bn), 32'd33);
    check({tag, ".hold"}, 32'(hb), 32'd0);
    expect_result(tag);
    @(posedge clock);
    #1;
    check({tag, ".done_pulse"}, 32'(Done), 32'd0);
  endtask

  task automatic do_mt(input logic [5:0] f, input logic [31:0] v);
    Md_valid = 1'b1;
    Function_opcode = f;
    Read_data_1 = v;
    @(negedge clock);
    check("mt.stall", 32'(Stall), 32'd0);
    @(posedge clock);
    #1;
    Md_valid = 1'b0;
    if (f == F_MTHI) m_hi = v;
    else m_lo = v;
  endtask

  task automatic do_mf(input logic [5:0] f, input string tag);
    Md_valid = 1'b1;
    Function_opcode = f;
    @(negedge clock);
    check({tag, ".stall"}, 32'(Stall), 32'd0);
    check({tag, ".value"}, Mf_Result, (f == F_MFHI) ? m_hi : m_lo);
    @(posedge clock);
    #1;
    Md_valid = 1'b0;
  endtask

  initial begin
    int          bn, sn, hb, dn;
    logic [5:0]  rf;
    logic [31:0] ra, rb;

    // Reset.
    reset = 1'b1;
    Md_valid = 1'b0;
    Function_opcode = F_ADD;
    Read_data_1 = 32'd0;
    Read_data_2 = 32'd0;
    m_hi = 32'd0;
    m_lo = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst.busy", 32'(Busy), 32'd0);
    check("rst.done", 32'(Done), 32'd0);
    check("rst.stall", 32'(Stall), 32'd0);
    check("rst.hi", Hi, 32'd0);
    check("rst.lo", Lo, 32'd0);
    do_mf(F_MFHI, "mf_idle");

    // Directed arithmetic corners.
    run_arith("mult_neg", F_MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    run_arith("multu_max", F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_arith("div_neg", F_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    run_arith("divu_zero", F_DIVU, 32'h0000_0064, 32'h0000_0000);
    run_arith("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_arith("div_zero", F_DIV, 32'h8765_4321, 32'h0000_0000);

    // Moves to and from HI/LO while idle.
    do_mt(F_MTLO, 32'hAABB_CCDD);
    do_mf(F_MFLO, "mflo");
    do_mt(F_MTHI, 32'h1122_3344);
    do_mf(F_MFHI, "mfhi");

    // Unrecognised funct in IDLE: no stall, no state change.
    Md_valid = 1'b1;
    Function_opcode = F_ADD;
    Read_data_1 = 32'hDEAD_BEEF;
    Read_data_2 = 32'h0000_0003;
    @(negedge clock);
    check("unrec.stall", 32'(Stall), 32'd0);
    @(posedge clock);
    #1;
    Md_valid = 1'b0;
    check("unrec.busy", 32'(Busy), 32'd0);
    check("unrec.hi", Hi, m_hi);
    check("unrec.lo", Lo, m_lo);

    // mflo presented from E4 onward: stalled while busy, reads new LO in Done cycle.
    start_op(F_MULT, 32'h0001_2345, 32'hFFFF_0F00);
    repeat (4) @(posedge clock);
    #1;
    Md_valid = 1'b1;
    Function_opcode = F_MFLO;
    wait_done(bn, sn, hb);
    check("mf_stall.busy", 32'(bn), 32'd29);
    check("mf_stall.count", 32'(sn), 32'd29);
    check("mf_stall.hold", 32'(hb), 32'd0);
    expect_result("mf_stall");
    check("mf_stall.done_stall", 32'(Stall), 32'd0);
    check("mf_stall.mf", Mf_Result, m_lo);
    @(posedge clock);
    #1;
    Md_valid = 1'b0;

    // mtlo presented during busy: stalled, lands only after the Done cycle.
    start_op(F_MULTU, 32'h0000_BEEF, 32'h0001_0001);
    Md_valid = 1'b1;
    Function_opcode = F_MTLO;
    Read_data_1 = 32'hCAFE_F00D;
    wait_done(bn, sn, hb);
    check("mt_stall.count", 32'(sn), 32'd33);
    check("mt_stall.hold", 32'(hb), 32'd0);
    expect_result("mt_stall");
    check("mt_stall.done_stall", 32'(Stall), 32'd0);
    @(posedge clock);
    #1;
    Md_valid = 1'b0;
    m_lo = 32'hCAFE_F00D;
    check("mt_stall.lo_after", Lo, m_lo);
    check("mt_stall.busy_after", 32'(Busy), 32'd0);

    // Back-to-back: second op held from E0+1, accepted at E33+1.
    start_op(F_DIV, 32'h7FFF_FFFF, 32'hFFFF_FFFD);
    Md_valid = 1'b1;
    Function_opcode = F_DIVU;
    Read_data_1 = 32'hF000_0001;
    Read_data_2 = 32'h0000_0013;
    wait_done(bn, sn, hb);
    check("b2b.stall_a", 32'(sn), 32'd33);
    expect_result("b2b_a");
    @(posedge clock);
    #1;
    Md_valid = 1'b0;
    exp_q.push_back(ref_md(F_DIVU, 32'hF000_0001, 32'h0000_0013));
    check("b2b.busy_b", 32'(Busy), 32'd1);
    wait_done(bn, sn, hb);
    check("b2b.busy_cycles_b", 32'(bn), 32'd33);
    expect_result("b2b_b");
    @(posedge clock);
    #1;

    // Random ops with unrecognised functs presented during busy.
    for (int i = 0; i < 16; i++) begin
      rf = F_MULT + 6'($urandom_range(0, 3));
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = $urandom_range(1, 15);
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      start_op(rf, ra, rb);
      Md_valid = 1'b1;
      Function_opcode = F_ADD + 6'($urandom_range(0, 7));
      wait_done(bn, sn, hb);
      check("rand.busy_cycles", 32'(bn), 32'd33);
      check("rand.unrec_stall", 32'(sn), 32'd0);
      check("rand.hold", 32'(hb), 32'd0);
      expect_result($sformatf("rand%0d_f%0h_%h_%h", i, rf, ra, rb));
      @(posedge clock);
      #1;
      Md_valid = 1'b0;
    end

    // Reset at E10 of a divide aborts it; HI/LO cleared, no late Done.
    do_mt(F_MTHI, 32'h5A5A_5A5A);
    do_mt(F_MTLO, 32'hA5A5_A5A5);
    start_op(F_DIV, 32'h0000_1000, 32'h0000_0003);
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    check("abort.busy", 32'(Busy), 32'd0);
    check("abort.done", 32'(Done), 32'd0);
    check("abort.hi", Hi, 32'd0);
    check("abort.lo", Lo, 32'd0);
    dn = 0;
    bn = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (Done) dn++;
      if (Busy) bn++;
    end
    @(posedge clock);
    #1;
    check("abort.late_done", 32'(dn), 32'd0);
    check("abort.late_busy", 32'(bn), 32'd0);
    do_mt(F_MTHI, 32'h1234_5678);
    do_mf(F_MFHI, "abort_mfhi");

    // Final report.
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle sequencer for the MIPS `mult`/`multu`/`div`/`divu` group, and owner of the architectural HI/LO registers. It sits beside the single-cycle ALU in the execute stage. It accepts an operation from decode, iterates a 32-step shift-add or restoring-divide datapath, and writes HI/LO. It raises `Stall` whenever the pipeline touches HI/LO while an operation is in flight.

## Interface
Parameters
- `ITER`, default 32: iterations per operation; fixed by the 32-bit data width, not meant to be overridden.

Ports
- `clock`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; dominates every other input
- `Md_valid`  in  1  decode presents a HI/LO-class instruction this cycle
- `Function_opcode`  in  6  R-type funct, instruction[5:0]
- `Read_data_1`  in  32  rs operand (multiplicand / dividend / mthi-mtlo source)
- `Read_data_2`  in  32  rt operand (multiplier / divisor)
- `Busy`  out  1  operation in flight
- `Done`  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle
- `Stall`  out  1  combinational; the pipeline must hold the current instruction
- `Hi`  out  32  HI register
- `Lo`  out  32  LO register
- `Mf_Result`  out  32  combinational; `Hi` for mfhi (010000), `Lo` for mflo (010010), else 0

## Operation
Recognised funct values when `Md_valid`=1:
- 011000 mult
- 011001 multu
- 011010 div
- 011011 divu
- 010000 mfhi
- 010001 mthi
- 010010 mflo
- 010011 mtlo
- Any other funct is ignored; no state change and no stall.

FSM: IDLE → CALC → FIX → IDLE.
- **IDLE, arithmetic op accepted:** latch operand magnitudes. For signed ops, magnitude = |x|, computed as two's complement of the 32-bit pattern. For unsigned ops, use the raw pattern. Latch the sign flags and the op type, clear the iteration counter, go to CALC.
- **IDLE, mthi/mtlo:** write `Read_data_1` into HI or LO at that edge. No Busy, no Done.
- **CALC (mult):** 64-bit accumulator, one multiplier bit per cycle, shift-add.
- **CALC (div):** restoring division, one quotient bit per cycle. 33-bit trial subtract of the divisor from the partial remainder. Keep the difference if it is non-negative.
- **CALC exit:** go to FIX after counter = ITER-1.
- **FIX, mult:** {HI,LO} = product. Negate the full 64 bits if signed and sa≠sb.
- **FIX, div:**
  - LO = quotient, negated if signed and sa≠sb.
  - HI = remainder, negated if signed and the dividend is negative.
- **FIX, divide by zero** (rt = 0, signed or unsigned): LO = FFFFFFFF, HI = rs original pattern. Latency is unchanged.
- **FIX, signed overflow** (80000000 / FFFFFFFF): LO = 80000000, HI = 00000000.
- **FIX exit:** assert Done, return to IDLE.
- **Stall** = `Md_valid` & recognised funct & `Busy`.
  - Stalled requests are not latched.
  - The pipeline re-presents the request; it is accepted in the cycle after Done.
- **Reset:** HI=LO=0, Busy=0, Done=0, state IDLE. Reset mid-operation aborts the operation; HI/LO go to 0, not to a partial result.

## Timing
- Accept edge E0: `Md_valid` with an arithmetic funct, state IDLE.
- `Busy`=1 from after E0 until E33.
- CALC iterations occur at edges E1–E32. The FIX write occurs at E33.
- After E33: `Busy`=0, `Done`=1 for exactly one cycle, `Hi`/`Lo` new.
- Latency is 33 cycles, regardless of op or operand values.
- Back-to-back: a new op is accepted at E33+1 at the earliest. No op is accepted in the same cycle as the FIX write.
- mthi/mtlo: the write lands at the accepting edge. An mfhi/mflo in the following cycle sees the new value.
- mfhi/mflo while idle: `Mf_Result` is valid combinationally in the same cycle, with no stall.
- `Hi`/`Lo` never change during CALC. Old values remain readable until E33, but reads are stalled by Busy.
- `Stall` is deasserted in the Done cycle. An mf request in that cycle reads the new result.

## Test plan
- mult rs=FFFFFFFD (−3), rt=00000007 → after E33, Done=1, HI=FFFFFFFF, LO=FFFFFFEB. Busy high for exactly 33 cycles.
- multu rs=FFFFFFFF, rt=FFFFFFFF → HI=FFFFFFFE, LO=00000001.
- div rs=FFFFFFF9 (−7), rt=00000002 → LO=FFFFFFFD, HI=FFFFFFFF. Then divu rs=00000064, rt=00000000 → LO=FFFFFFFF, HI=00000064.
- div rs=80000000, rt=FFFFFFFF → LO=80000000, HI=00000000, no X or hang.
- Start mult, then assert mflo at E5 → Stall=1 through E32 and 0 in the Done cycle, with Mf_Result = new LO. An mtlo presented during Busy is likewise stalled and not written early.
- Start div, assert reset at E10 → next cycle Busy=0, Done=0, HI=LO=0, no Done pulse later. mthi 12345678 then mfhi → Mf_Result=12345678 one cycle later.
